// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Latches eight 6-bit symbol codes into a shadow bank and time-multiplexes them
//   onto an 8-digit common-anode seven-segment display. Each digit slot lasts
//   CLK_DIV cycles. All anodes stay off for the first GUARD cycles of a slot so
//   the previous digit's pattern cannot ghost onto the next one. A digit whose
//   blink_en bit is set has its cathodes blanked during odd blink phases. Each
//   blink phase lasts BLINK_FRAMES full scan frames.
//
// Ports
//   clock     : system clock
//   reset     : synchronous, active-high reset
//   d1..d8    : symbol codes; d1 drives the rightmost digit (an[0]), d8 the leftmost (an[7])
//   load      : level-sensitive; while high, the shadow bank copies d1..d8 at every rising edge
//   blink_en  : bit i set makes digit i blink
//   an        : active-low anode enables, one-hot-low or all ones
//   cat       : active-low cathodes, cat[0]=a .. cat[6]=g, cat[7]=dp (always 1)

module display_scan_driver #(
    parameter int CLK_DIV      = 100000,  // cycles per digit slot, >= 4
    parameter int GUARD        = 16,      // anode-off cycles at slot start, < CLK_DIV
    parameter int BLINK_FRAMES = 64       // scan frames per blink half-period, >= 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    input  logic       load,
    input  logic [7:0] blink_en,
    output logic [7:0] an,
    output logic [7:0] cat
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [5:0]       CODE_BLANK = 6'd20;

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       scan_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic [5:0]       shadow [8];
    logic [5:0]       d_bus  [8];

    logic             tick;
    logic [5:0]       active_code;
    logic [7:0]       an_next;
    logic [7:0]       cat_next;

    // Lit-segment mask (bit0=a .. bit6=g) turned into an active-low cathode byte.
    // Codes outside the table light nothing.
    function automatic logic [7:0] decode(input logic [5:0] code);
        logic [6:0] lit;
        case (code)
            6'd0:    lit = 7'h3F;  // 0
            6'd1:    lit = 7'h06;  // 1
            6'd2:    lit = 7'h5B;  // 2
            6'd3:    lit = 7'h4F;  // 3
            6'd4:    lit = 7'h66;  // 4
            6'd5:    lit = 7'h6D;  // 5
            6'd6:    lit = 7'h7D;  // 6
            6'd7:    lit = 7'h07;  // 7
            6'd8:    lit = 7'h7F;  // 8
            6'd9:    lit = 7'h6F;  // 9
            6'd10:   lit = 7'h73;  // P
            6'd11:   lit = 7'h6D;  // S
            6'd12:   lit = 7'h3E;  // U
            6'd13:   lit = 7'h79;  // E
            6'd14:   lit = 7'h50;  // r
            6'd15:   lit = 7'h7C;  // b
            6'd16:   lit = 7'h39;  // C
            6'd17:   lit = 7'h3D;  // G
            6'd18:   lit = 7'h38;  // L
            6'd19:   lit = 7'h40;  // dash
            default: lit = 7'h00;  // blank
        endcase
        return {1'b1, ~lit};
    endfunction

    assign d_bus[0] = d1;
    assign d_bus[1] = d2;
    assign d_bus[2] = d3;
    assign d_bus[3] = d4;
    assign d_bus[4] = d5;
    assign d_bus[5] = d6;
    assign d_bus[6] = d7;
    assign d_bus[7] = d8;

    assign tick        = (prescaler == PRE_LAST);
    assign active_code = shadow[scan_idx];

    // Next output values come from the pre-edge counters, which gives one cycle of latency.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        an_next  = 8'hFF;
        cat_next = 8'hFF;
        if (prescaler >= GUARD_END) begin
            an_next = ~(8'b1 << scan_idx);
            // A blinking digit keeps its anode driven and only blanks its cathodes.
            if (!(blink_en[scan_idx] && blink_phase)) begin
                cat_next = decode(active_code);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler   <= '0;
            scan_idx    <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            an          <= 8'hFF;
            cat         <= 8'hFF;
            // NOTE: the shadow bank is reset on purpose so the display starts blank;
            // this stops it from mapping to a RAM macro, which is fine for eight entries.
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= CODE_BLANK;
            end
        end else begin
            // NOTE: non-blocking assignments, so every register sees pre-edge values.
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                scan_idx <= scan_idx + 3'd1;
                if (scan_idx == 3'd7) begin
                    if (frame_cnt == FRM_LAST) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
            if (load) begin
                for (int i = 0; i < 8; i++) begin
                    shadow[i] <= d_bus[i];
                end
            end
            an  <= an_next;
            cat <= cat_next;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Testbench for display_scan_driver with CLK_DIV=8, GUARD=2, BLINK_FRAMES=2.
// A reference model derives each output from the count of cycles since reset
// and a copy of the loaded codes. A compare process checks both outputs on every
// falling edge. Directed steps add hand-computed literal expectations.

module tb_display_scan_driver;

    localparam int CLK_DIV      = 8;
    localparam int GUARD        = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = CLK_DIV * 8;
    localparam int PHASE_CYC    = FRAME_CYC * BLINK_FRAMES;

    logic       clock;
    logic       reset;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       load;
    logic [7:0] blink_en;
    logic [7:0] an;
    logic [7:0] cat;

    int n_cmp = 0;
    int n_bad = 0;

    display_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .GUARD        (GUARD),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6),
        .d7       (d7),
        .d8       (d8),
        .load     (load),
        .blink_en (blink_en),
        .an       (an),
        .cat      (cat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Segment spellings for codes 0..19. Any other code is blank.
    string seg_names [20] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                              "abc", "abcdefg", "abcdfg", "abefg", "acdfg", "bcdef",
                              "adefg", "eg", "cdefg", "adef", "acdef", "def", "g"};

    function automatic logic [7:0] seg_of(input int code);
        logic [6:0] lit;
        int idx;
        lit = '0;
        if (code > 19) return 8'hFF;
        for (int i = 0; i < seg_names[code].len(); i++) begin
            idx = int'(seg_names[code][i]) - 97;
            lit[idx] = 1'b1;
        end
        return {1'b1, ~lit};
    endfunction

    int         mdl_n = 0;      // cycles elapsed since the last reset edge
    bit         mdl_valid = 0;
    int         mdl_shadow [8];
    logic [7:0] exp_an, exp_cat;

    always @(posedge clock) begin
        int pre, slot, phase;
        if (reset) begin
            exp_an  = 8'hFF;
            exp_cat = 8'hFF;
            mdl_n   = 0;
            for (int i = 0; i < 8; i++) mdl_shadow[i] = 20;
            mdl_valid = 1;
        end else begin
            pre   = mdl_n % CLK_DIV;
            slot  = (mdl_n / CLK_DIV) % 8;
            phase = (mdl_n / PHASE_CYC) % 2;
            if (pre < GUARD) begin
                exp_an  = 8'hFF;
                exp_cat = 8'hFF;
            end else begin
                exp_an  = 8'hFF;
                exp_an[slot] = 1'b0;
                exp_cat = (blink_en[slot] && phase == 1) ? 8'hFF : seg_of(mdl_shadow[slot]);
            end
            mdl_n++;
            if (load) begin
                mdl_shadow[0] = int'(d1); mdl_shadow[1] = int'(d2);
                mdl_shadow[2] = int'(d3); mdl_shadow[3] = int'(d4);
                mdl_shadow[4] = int'(d5); mdl_shadow[5] = int'(d6);
                mdl_shadow[6] = int'(d7); mdl_shadow[7] = int'(d8);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mdl_valid) begin
            check("model_an", an, exp_an);
            check("model_cat", cat, exp_cat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_d(input int v8, input int v7, input int v6, input int v5,
                         input int v4, input int v3, input int v2, input int v1);
        d8 = 6'(v8); d7 = 6'(v7); d6 = 6'(v6); d5 = 6'(v5);
        d4 = 6'(v4); d3 = 6'(v3); d2 = 6'(v2); d1 = 6'(v1);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    // Wait for the falling edge at which the outputs show the given slot, prescaler
    // value and blink phase (phase -1 means any phase).
    task automatic wait_disp(input int slot, input int pre, input int phase);
        bit hit;
        int k;
        hit = 0;
        for (k = 0; k < 2000 && !hit; k++) begin
            @(negedge clock);
            if (mdl_n >= 1 && ((mdl_n - 1) % CLK_DIV) == pre &&
                (((mdl_n - 1) / CLK_DIV) % 8) == slot &&
                (phase < 0 || (((mdl_n - 1) / PHASE_CYC) % 2) == phase))
                hit = 1;
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_disp: slot %0d pre %0d not reached, got none expected reached", slot, pre);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        load = 1'b0;
        blink_en = 8'h00;
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("reset_an", an, 8'hFF);
        check("reset_cat", cat, 8'hFF);
        reset = 1'b0;

        // Blank after reset: first non-guard output of slot 0.
        wait_disp(0, 2, -1);
        check("blank_an", an, 8'hFE);
        check("blank_cat", cat, 8'hFF);

        // Load P,1,blank,S,U,0,0,0 on d8..d1.
        set_d(10, 1, 20, 11, 12, 0, 0, 0);
        pulse_load();
        wait_disp(7, 2, -1);
        check("slot7_an", an, 8'h7F);
        check("slot7_cat_P", cat, 8'h8C);
        wait_disp(0, 3, -1);
        check("slot0_cat_0", cat, 8'hC0);
        wait_disp(5, 4, -1);
        check("slot5_an", an, 8'hDF);
        check("slot5_cat_blank", cat, 8'hFF);
        wait_disp(6, 2, -1);
        check("slot6_cat_1", cat, 8'hF9);

        // Guard window at the start of slot 3.
        wait_disp(3, 0, -1);
        check("guard0_an", an, 8'hFF);
        check("guard0_cat", cat, 8'hFF);
        wait_disp(3, 1, -1);
        check("guard1_an", an, 8'hFF);
        wait_disp(3, 2, -1);
        check("slot3_an", an, 8'hF7);
        check("slot3_cat_U", cat, 8'hC1);
        repeat (64) @(negedge clock);

        // Blink digit 7 showing 2.
        blink_en = 8'h80;
        d8 = 6'd2;
        pulse_load();
        wait_disp(7, 2, 0);
        check("blink_on_cat", cat, 8'hA4);
        wait_disp(7, 3, 1);
        check("blink_off_an", an, 8'h7F);
        check("blink_off_cat", cat, 8'hFF);
        wait_disp(0, 2, 1);
        check("blink_other_cat", cat, 8'hC0);
        wait_disp(7, 5, 0);
        check("blink_again_cat", cat, 8'hA4);
        repeat (300) @(negedge clock);

        // Reset in slot 5 with prescaler 4.
        blink_en = 8'h00;
        wait_disp(5, 3, -1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_an", an, 8'hFF);
        check("midrst_cat", cat, 8'hFF);
        reset = 1'b0;
        wait_disp(7, 3, -1);
        check("midrst_shadow_an", an, 8'h7F);
        check("midrst_shadow_cat", cat, 8'hFF);

        // Out-of-table code 63 on d3.
        set_d(2, 1, 20, 11, 12, 63, 0, 0);
        pulse_load();
        wait_disp(2, 4, -1);
        check("code63_an", an, 8'hFB);
        check("code63_cat", cat, 8'hFF);
        wait_disp(7, 2, -1);
        check("slot7_cat_2", cat, 8'hA4);

        // Load on the tick edge into slot 1 (state: slot 0, prescaler 7).
        wait_disp(0, 6, -1);
        d2 = 6'd9;
        pulse_load();
        wait_disp(1, 2, -1);
        check("tickload_an", an, 8'hFD);
        check("tickload_cat_9", cat, 8'h90);

        repeat (20) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
